tsu_queue_arb: RTL and testbench

Drains the timestamp queues of the RX and TX `tsu` instances into a single valid/ready timestamp stream for the host register interface. It sits in the `q_rd_clk` domain between the two TSU queue read ports and the host-side consumer. It arbitrates round-robin, with watermark priority so a nearly full queue is served first, and keeps per-direction drain counters.

---
 rtl/tsu_queue_arb.sv | 112 +++++++++++
 tb/tb_tsu_queue_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tsu_queue_arb.sv
// Drains the RX and TX TSU timestamp queues into one registered valid/ready stream.
// Grants are round-robin, a queue at or above the watermark goes first, and each direction has a drain counter.
module tsu_queue_arb #(
   parameter logic [7:0] HIWAT = 8'd12,
   parameter int         CNT_W = 16
) (
   input  logic             q_rd_clk,
   input  logic             rst_n,
   input  logic             arb_en,
   output logic             rx_q_rd_en,
   input  logic [7:0]       rx_q_rd_stat,
   input  logic [127:0]     rx_q_rd_data,
   output logic             tx_q_rd_en,
   input  logic [7:0]       tx_q_rd_stat,
   input  logic [127:0]     tx_q_rd_data,
   output logic             ts_valid,
   input  logic             ts_ready,
   output logic [127:0]     ts_data,
   output logic             ts_src,
   output logic [CNT_W-1:0] cnt_rx,
   output logic [CNT_W-1:0] cnt_tx
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPT, S_HOLD} state_t;

   state_t state, state_nxt;
   logic   grant, grant_nxt;
   logic   lsp;
   logic   rx_hi, tx_hi, rx_any, tx_any;
   logic   pick;
   logic   handshake;

   // Watermark beats occupancy, and occupancy beats the round-robin pointer.
   // If both queues are above the watermark, the round-robin pointer decides.
   always_comb begin
      rx_hi  = (rx_q_rd_stat >= HIWAT);
      tx_hi  = (tx_q_rd_stat >= HIWAT);
      rx_any = (rx_q_rd_stat != 8'd0);
      tx_any = (tx_q_rd_stat != 8'd0);
      pick   = ~lsp;
      if (rx_hi != tx_hi) begin
         pick = tx_hi;
      end else if (rx_any != tx_any) begin
         pick = tx_any;
      end
   end

   assign handshake = (state == S_HOLD) && ts_ready;

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      case (state)
         S_IDLE: begin
            if (arb_en && (rx_any || tx_any)) begin
               state_nxt = S_ISSUE;
               grant_nxt = pick;
            end
         end
         S_ISSUE: state_nxt = S_CAPT;
         S_CAPT:  state_nxt = S_HOLD;
         S_HOLD: begin
            if (ts_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge q_rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         grant <= 1'b0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
      end
   end

   // Outputs are registered from the next state, so each strobe lines up with its state.
   // The read strobe is high for exactly the ISSUE cycle.
   always_ff @(posedge q_rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q_rd_en <= 1'b0;
         tx_q_rd_en <= 1'b0;
         ts_valid   <= 1'b0;
         ts_data    <= '0;
         ts_src     <= 1'b0;
         cnt_rx     <= '0;
         cnt_tx     <= '0;
         lsp        <= 1'b1;
      end else begin
         rx_q_rd_en <= (state_nxt == S_ISSUE) && !grant_nxt;
         tx_q_rd_en <= (state_nxt == S_ISSUE) && grant_nxt;
         ts_valid   <= (state_nxt == S_HOLD);
         if (state == S_CAPT) begin
            ts_data <= grant ? tx_q_rd_data : rx_q_rd_data;
            ts_src  <= grant;
         end
         if (handshake) begin
            lsp <= grant;
            if (ts_src) begin
               cnt_tx <= cnt_tx + CNT_W'(1);
            end else begin
               cnt_rx <= cnt_rx + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_tsu_queue_arb.sv
// Randomized-data bench for tsu_queue_arb: queue models feed the DUT and a
// reference arbiter predicts every delivered entry and counter value.
module tb_tsu_queue_arb;

   localparam int CNT_W = 4;

   logic             q_rd_clk = 1'b0;
   logic             rst_n;
   logic             arb_en;
   logic             rx_q_rd_en, tx_q_rd_en;
   logic [7:0]       rx_q_rd_stat, tx_q_rd_stat;
   logic [127:0]     rx_q_rd_data, tx_q_rd_data;
   logic             ts_valid, ts_ready, ts_src;
   logic [127:0]     ts_data;
   logic [CNT_W-1:0] cnt_rx, cnt_tx;

   int checks = 0;
   int fails  = 0;

   logic [127:0]     rx_q[$], tx_q[$], rx_exp[$], tx_exp[$];
   bit               m_lsp;
   logic [CNT_W-1:0] m_cnt_rx, m_cnt_tx;
   int               rx_pulses, tx_pulses;

   tsu_queue_arb #(.HIWAT(8'd12), .CNT_W(CNT_W)) dut (
      .q_rd_clk     (q_rd_clk),
      .rst_n        (rst_n),
      .arb_en       (arb_en),
      .rx_q_rd_en   (rx_q_rd_en),
      .rx_q_rd_stat (rx_q_rd_stat),
      .rx_q_rd_data (rx_q_rd_data),
      .tx_q_rd_en   (tx_q_rd_en),
      .tx_q_rd_stat (tx_q_rd_stat),
      .tx_q_rd_data (tx_q_rd_data),
      .ts_valid     (ts_valid),
      .ts_ready     (ts_ready),
      .ts_data      (ts_data),
      .ts_src       (ts_src),
      .cnt_rx       (cnt_rx),
      .cnt_tx       (cnt_tx)
   );

   always #5 q_rd_clk = ~q_rd_clk;

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference arbiter: 1 = TX, 0 = RX.
   function automatic bit model_pick(input int nrx, input int ntx, input bit last);
      bit rh, th;
      rh = (nrx >= 12);
      th = (ntx >= 12);
      if (rh != th) return th;
      if ((nrx > 0) != (ntx > 0)) return (ntx > 0);
      return !last;
   endfunction

   task automatic apply_stimulus(input bit src, input int n);
      logic [127:0] d;
      for (int i = 0; i < n; i++) begin
         d = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (src) begin
            tx_q.push_back(d);
            tx_exp.push_back(d);
         end else begin
            rx_q.push_back(d);
            rx_exp.push_back(d);
         end
      end
      rx_q_rd_stat = 8'(rx_q.size());
      tx_q_rd_stat = 8'(tx_q.size());
   endtask

   // One clock: queue model reacts to read strobes, scoreboard checks the
   // handshake that the coming edge will perform, counters checked after it.
   task automatic step();
      bit           hs, src;
      logic [127:0] d;
      hs = ts_valid && ts_ready;
      if (rx_q_rd_en || tx_q_rd_en) check_output("rd_en_onehot", rx_q_rd_en & tx_q_rd_en, 0);
      if (rx_q_rd_en) begin
         rx_pulses++;
         if (rx_q.size() > 0) rx_q_rd_data = rx_q.pop_front();
         rx_q_rd_stat = 8'(rx_q.size());
      end
      if (tx_q_rd_en) begin
         tx_pulses++;
         if (tx_q.size() > 0) tx_q_rd_data = tx_q.pop_front();
         tx_q_rd_stat = 8'(tx_q.size());
      end
      if (hs) begin
         src = model_pick(rx_exp.size(), tx_exp.size(), m_lsp);
         d   = '0;
         if (src && tx_exp.size() > 0) d = tx_exp.pop_front();
         if (!src && rx_exp.size() > 0) d = rx_exp.pop_front();
         check_output("ts_src", ts_src, src);
         check_output("ts_data", ts_data, d);
         m_lsp = src;
         if (src) m_cnt_tx = m_cnt_tx + 1'b1;
         else     m_cnt_rx = m_cnt_rx + 1'b1;
      end
      @(negedge q_rd_clk);
      if (hs) begin
         check_output("cnt_rx", cnt_rx, m_cnt_rx);
         check_output("cnt_tx", cnt_tx, m_cnt_tx);
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((rx_exp.size() > 0 || tx_exp.size() > 0 || ts_valid) && n < budget) begin
         step();
         n++;
      end
      check_output("drain_timeout", n >= budget, 0);
   endtask

   initial begin
      int           n;
      bit           p_src;
      logic [127:0] p_data;
      rst_n        = 1'b0;
      arb_en       = 1'b0;
      ts_ready     = 1'b0;
      rx_q_rd_stat = 8'd0;
      tx_q_rd_stat = 8'd0;
      rx_q_rd_data = '0;
      tx_q_rd_data = '0;
      m_lsp        = 1'b1;
      m_cnt_rx     = '0;
      m_cnt_tx     = '0;
      rx_pulses    = 0;
      tx_pulses    = 0;

      #3;
      check_output("rst_rx_rd_en", rx_q_rd_en, 0);
      check_output("rst_tx_rd_en", tx_q_rd_en, 0);
      check_output("rst_ts_valid", ts_valid, 0);
      check_output("rst_ts_data", ts_data, 0);
      check_output("rst_ts_src", ts_src, 0);
      check_output("rst_cnt_rx", cnt_rx, 0);
      check_output("rst_cnt_tx", cnt_tx, 0);
      @(negedge q_rd_clk);
      @(negedge q_rd_clk);
      rst_n = 1'b1;

      arb_en   = 1'b1;
      ts_ready = 1'b1;
      repeat (100) step();
      check_output("idle_rx_pulses", rx_pulses, 0);
      check_output("idle_tx_pulses", tx_pulses, 0);
      check_output("idle_ts_valid", ts_valid, 0);

      apply_stimulus(1'b0, 3);
      drain(200);
      check_output("rxonly_rx_pulses", rx_pulses, 3);
      check_output("rxonly_tx_pulses", tx_pulses, 0);
      check_output("rxonly_cnt_rx", cnt_rx, 3);
      check_output("rxonly_cnt_tx", cnt_tx, 0);

      rx_pulses = 0;
      tx_pulses = 0;
      apply_stimulus(1'b0, 4);
      apply_stimulus(1'b1, 4);
      drain(400);
      check_output("rr_rx_pulses", rx_pulses, 4);
      check_output("rr_tx_pulses", tx_pulses, 4);

      apply_stimulus(1'b0, 2);
      apply_stimulus(1'b1, 12);
      drain(800);

      ts_ready = 1'b0;
      apply_stimulus(1'b0, 1);
      apply_stimulus(1'b1, 1);
      p_src  = model_pick(rx_exp.size(), tx_exp.size(), m_lsp);
      p_data = p_src ? tx_exp[0] : rx_exp[0];
      n = 0;
      while (!ts_valid && n < 20) begin
         step();
         n++;
      end
      check_output("bp_valid_timeout", n >= 20, 0);
      rx_pulses = 0;
      tx_pulses = 0;
      repeat (50) step();
      check_output("bp_ts_data", ts_data, p_data);
      check_output("bp_ts_src", ts_src, p_src);
      check_output("bp_ts_valid", ts_valid, 1);
      check_output("bp_pulses", rx_pulses + tx_pulses, 0);
      arb_en = 1'b0;
      step();
      ts_ready = 1'b1;
      repeat (20) step();
      check_output("arb_off_pulses", rx_pulses + tx_pulses, 0);
      check_output("arb_off_valid", ts_valid, 0);
      check_output("arb_off_left", rx_exp.size() + tx_exp.size(), 1);
      arb_en = 1'b1;
      drain(100);

      apply_stimulus(1'b0, 17);
      drain(1000);

      apply_stimulus(1'b0, 1);
      n = 0;
      while (!rx_q_rd_en && n < 20) begin
         step();
         n++;
      end
      check_output("issue_timeout", n >= 20, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check_output("async_rx_rd_en", rx_q_rd_en, 0);
      check_output("async_ts_valid", ts_valid, 0);
      check_output("async_cnt_rx", cnt_rx, 0);
      check_output("async_cnt_tx", cnt_tx, 0);
      check_output("async_ts_data", ts_data, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
